// File: rtl/sobel_hc_csr_pkg.sv
// Shared types for the Sobel host-control CSR block: a minimal CCI-P channel
// subset, MMIO register map, command codes and the DSM status line layout.
package sobel_hc_csr_pkg;

  typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1} t_ccip_c1_req;
  typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4} t_ccip_c1_rsp;
  typedef enum logic [1:0] {eVC_VA = 2'b00, eVC_VL0 = 2'b01, eVC_VH0 = 2'b10, eVC_VH1 = 2'b11} t_ccip_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_cl_len;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_req_mmio_hdr;

  typedef struct packed {
    t_ccip_c0_req_mmio_hdr hdr;
    logic [511:0]          data;
    logic                  rspValid;
    logic                  mmioRdValid;
    logic                  mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_rsp_mem_hdr;

  typedef struct packed {
    t_ccip_c1_rsp_mem_hdr hdr;
    logic                 rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_cl_len cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c1_req_mem_hdr;

  typedef struct packed {
    t_ccip_c1_req_mem_hdr hdr;
    logic [511:0]         data;
    logic                 valid;
  } t_if_ccip_c1_Tx;

  typedef logic [17:0] t_hc_addr;

  localparam t_hc_addr HC_DSM_BASE   = 18'h110;
  localparam t_hc_addr HC_CONTROL    = 18'h118;
  localparam t_hc_addr HC_BUF_ADDR0  = 18'h120;
  localparam t_hc_addr HC_BUF_SIZE0  = 18'h128;
  localparam t_hc_addr HC_BUF_STRIDE = 18'h010;

  localparam logic [31:0] HC_CONTROL_RESET = 32'h0;
  localparam logic [31:0] HC_CONTROL_INIT  = 32'h1;
  localparam logic [31:0] HC_CONTROL_START = 32'h3;
  localparam logic [31:0] HC_CONTROL_STOP  = 32'h7;

  localparam logic [15:0] DSM_MDATA = 16'h5D5D;

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_IDLE     = 3'd1,
    S_RUN      = 3'd2,
    S_DSM_WR   = 3'd3,
    S_DSM_WAIT = 3'd4,
    S_DONE     = 3'd5
  } t_ctl_state;

  typedef struct packed {
    logic [447:0] pad1;
    logic [31:0]  cycles;
    logic [30:0]  pad0;
    logic         done;
  } t_dsm_status;

  function automatic logic hc_dsm_base_sel(input t_hc_addr a);
    return a == HC_DSM_BASE;
  endfunction

  function automatic logic hc_control_sel(input t_hc_addr a);
    return a == HC_CONTROL;
  endfunction

  function automatic logic hc_buf_addr_sel(input t_hc_addr a, input int i);
    return a == (HC_BUF_ADDR0 + HC_BUF_STRIDE * t_hc_addr'(i));
  endfunction

  function automatic logic hc_buf_size_sel(input t_hc_addr a, input int i);
    return a == (HC_BUF_SIZE0 + HC_BUF_STRIDE * t_hc_addr'(i));
  endfunction

endpackage

// File: rtl/sobel_hc_desc_regs.sv
// Buffer descriptor table (address and size per buffer); host writes are
// dropped while the protect input is high so a running job sees stable values.
module sobel_hc_desc_regs
  import sobel_hc_csr_pkg::*;
#(
  parameter int N_BUF = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  t_hc_addr               wr_addr,
  input  logic [63:0]            wr_data,
  input  logic                   wr_protect,
  output logic [N_BUF-1:0][63:0] buf_addr,
  output logic [N_BUF-1:0][31:0] buf_size
);

  logic [N_BUF-1:0][63:0] addr_r;
  logic [N_BUF-1:0][31:0] size_r;

  // descriptor storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
      size_r <= '0;
    end else if (wr_en && !wr_protect) begin
      for (int i = 0; i < N_BUF; i++) begin
        if (hc_buf_addr_sel(wr_addr, i)) addr_r[i] <= wr_data;
        if (hc_buf_size_sel(wr_addr, i)) size_r[i] <= wr_data[31:0];
      end
    end
  end

  assign buf_addr = addr_r;
  assign buf_size = size_r;

endmodule

// File: rtl/sobel_hc_csr.sv
// MMIO control/status front end of the Sobel accelerator: register decode,
// lifecycle FSM and the completion status write to DSM.
module sobel_hc_csr
  import sobel_hc_csr_pkg::*;
#(
  parameter int N_BUF = 2,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  t_if_ccip_c0_Rx         rx_mmio,
  input  t_if_ccip_c1_Rx         rx_c1,
  input  logic                   c1_alm_full,
  output t_if_ccip_c1_Tx         tx_c1,
  input  logic                   dp_done,
  output logic                   dp_rst,
  output logic                   dp_start,
  output logic [N_BUF-1:0][63:0] buf_addr,
  output logic [N_BUF-1:0][31:0] buf_size,
  output logic                   busy
);

  logic             mmio_wr_s;
  t_hc_addr         mmio_addr_s;
  logic             cmd_vld_s;
  logic [31:0]      cmd_s;
  logic             cmd_reset_s, cmd_init_s, cmd_start_s, cmd_stop_s;
  logic             wr_rsp_s;
  t_ctl_state       state_r, state_s;
  logic [63:0]      dsm_base_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dp_rst_r, dp_start_r, busy_r, tx_valid_r;
  t_dsm_status      dsm_status_s;
  logic             unused_s;

  assign mmio_wr_s   = rx_mmio.mmioWrValid && (rx_mmio.hdr.address < 16'h0100);
  assign mmio_addr_s = {rx_mmio.hdr.address, 2'b00};
  assign cmd_vld_s   = mmio_wr_s && hc_control_sel(mmio_addr_s);
  assign cmd_s       = rx_mmio.data[31:0];
  assign cmd_reset_s = cmd_vld_s && (cmd_s == HC_CONTROL_RESET);
  assign cmd_init_s  = cmd_vld_s && (cmd_s == HC_CONTROL_INIT);
  assign cmd_start_s = cmd_vld_s && (cmd_s == HC_CONTROL_START);
  assign cmd_stop_s  = cmd_vld_s && (cmd_s == HC_CONTROL_STOP);
  assign wr_rsp_s    = rx_c1.rspValid && (rx_c1.hdr.resp_type == eRSP_WRLINE);
  assign unused_s    = ^{rx_mmio, rx_c1, dsm_base_r};

  // next-state: reset command beats stop, stop beats datapath completion
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_RESET: begin
        if (cmd_init_s) state_s = S_IDLE;
        else            state_s = state_r;
      end
      S_IDLE: begin
        if (cmd_start_s)      state_s = S_RUN;
        else if (cmd_reset_s) state_s = S_RESET;
        else                  state_s = state_r;
      end
      S_RUN: begin
        if (cmd_reset_s)     state_s = S_RESET;
        else if (cmd_stop_s) state_s = S_IDLE;
        else if (dp_done)    state_s = S_DSM_WR;
        else                 state_s = state_r;
      end
      S_DSM_WR: begin
        if (cmd_reset_s)       state_s = S_RESET;
        else if (!c1_alm_full) state_s = S_DSM_WAIT;
        else                   state_s = state_r;
      end
      S_DSM_WAIT: begin
        if (cmd_reset_s)   state_s = S_RESET;
        else if (wr_rsp_s) state_s = S_DONE;
        else               state_s = state_r;
      end
      S_DONE: begin
        if (cmd_start_s)      state_s = S_RUN;
        else if (cmd_init_s)  state_s = S_IDLE;
        else if (cmd_reset_s) state_s = S_RESET;
        else                  state_s = state_r;
      end
      default: state_s = S_RESET;
    endcase
  end

  // state register and outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_RESET;
      dp_rst_r   <= 1'b1;
      dp_start_r <= 1'b0;
      busy_r     <= 1'b0;
      tx_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      dp_rst_r   <= (state_s == S_RESET);
      dp_start_r <= (state_s == S_RUN) && (state_r != S_RUN);
      busy_r     <= (state_s == S_RUN) || (state_s == S_DSM_WR) || (state_s == S_DSM_WAIT);
      tx_valid_r <= (state_r == S_DSM_WR) && (state_s == S_DSM_WAIT);
    end
  end

  // run cycle counter: cleared on run entry, frozen once the run ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if ((state_s == S_RUN) && (state_r != S_RUN)) begin
      cnt_r <= '0;
    end else if ((state_r == S_RUN) && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // DSM base register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsm_base_r <= 64'h0;
    end else if (mmio_wr_s && hc_dsm_base_sel(mmio_addr_s)) begin
      dsm_base_r <= rx_mmio.data[63:0];
    end
  end

  sobel_hc_desc_regs #(.N_BUF(N_BUF)) u_desc (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (mmio_wr_s),
    .wr_addr    (mmio_addr_s),
    .wr_data    (rx_mmio.data[63:0]),
    .wr_protect (busy_r),
    .buf_addr   (buf_addr),
    .buf_size   (buf_size)
  );

  // DSM status line and request header, built from registered values only
  always_comb begin
    dsm_status_s        = '0;
    dsm_status_s.done   = 1'b1;
    dsm_status_s.cycles = 32'(cnt_r);
    tx_c1               = '0;
    tx_c1.hdr.req_type  = eREQ_WRLINE_I;
    tx_c1.hdr.vc_sel    = eVC_VA;
    tx_c1.hdr.sop       = 1'b1;
    tx_c1.hdr.cl_len    = eCL_LEN_1;
    tx_c1.hdr.mdata     = DSM_MDATA;
    tx_c1.hdr.address   = dsm_base_r[47:6];
    tx_c1.data          = dsm_status_s;
    tx_c1.valid         = tx_valid_r;
  end

  assign dp_rst   = dp_rst_r;
  assign dp_start = dp_start_r;
  assign busy     = busy_r;

endmodule
